// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the IF/ID register.
// Owns the pc, issues in-order requests on a req/gnt/rvalid port,
// buffers returned words in a DEPTH-entry FIFO and presents one
// {pc, instr} pair per cycle. Redirects flush the FIFO and discard
// responses that are still in flight.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to halt fetch on a
// redirect to a non word-aligned address and expose fetch_misaligned.
//
// Handshakes: a request transfers on a cycle where imem_req && imem_gnt;
// a response transfers on every cycle imem_rvalid is high, in request
// order; downstream consumes the head when if_valid && !stall.
module fetch_unit #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned      DEPTH     = 2,
   parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic             if_valid,
   output logic [WIDTH-1:0] if_pc,
   output logic [WIDTH-1:0] if_instr
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic             fetch_misaligned
`endif
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [WIDTH-1:0] fifo_pc_q    [DEPTH];
   logic [WIDTH-1:0] fifo_instr_q [DEPTH];

   logic             fetch_en;
   logic             resp_ok;
   logic             push;
   logic             pop;
   logic [CNT_W:0]   inflight;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic halted_q, halted_d;
   assign fetch_en         = !halted_q;
   assign fetch_misaligned = halted_q;
`else
   assign fetch_en = 1'b1;
`endif

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign if_valid  = (count_q != '0);
   assign if_pc     = if_valid ? fifo_pc_q[rd_ptr_q]    : '0;
   assign if_instr  = if_valid ? fifo_instr_q[rd_ptr_q] : NOP_INSTR;
   assign imem_addr = pc_q;
   assign pop       = if_valid && !stall;
   assign resp_ok   = imem_rvalid && (outstanding_q != '0);

   // The head leaving this cycle frees its slot for a new request, so a
   // 1-cycle memory can keep one word in flight and one buffered every
   // cycle; the occupancy cap still holds after the edge.
   assign inflight  = {1'b0, outstanding_q} + {1'b0, count_q} - {{CNT_W{1'b0}}, pop};
   assign imem_req  = rst && !redirect_valid && fetch_en && (inflight < (CNT_W+1)'(DEPTH));

   // Next-state: issue, response accounting, FIFO push/pop, redirect flush.
   always_comb begin
      pc_d          = pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      push          = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      halted_d      = halted_q;
`endif
      if (imem_req && imem_gnt) begin
         pc_d          = pc_q + WIDTH'(4);
         outstanding_d = outstanding_d + CNT_W'(1);
      end
      if (resp_ok) begin
         outstanding_d = outstanding_d - CNT_W'(1);
      end
      if (redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old path.
         pc_d       = redirect_pc;
         resp_pc_d  = redirect_pc;
         drop_cnt_d = outstanding_d;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
         halted_d   = (redirect_pc[1:0] != 2'b00);
`endif
      end else begin
         if (resp_ok) begin
            if (drop_cnt_q != '0) begin
               drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end else begin
               push      = 1'b1;
               resp_pc_d = resp_pc_q + WIDTH'(4);
            end
         end
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q          <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
         halted_q      <= 1'b0;
`endif
      end else begin
         pc_q          <= pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
         halted_q      <= halted_d;
`endif
      end
   end

   // FIFO storage write; contents are only meaningful below count_q.
   always_ff @(posedge clk) begin
      if (rst && push) begin
         fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
         fifo_instr_q[wr_ptr_q] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an in-order
// instruction memory model (responses one cycle after grant, or later
// when held back). Covers FETCH_MISALIGN_CHECK_EN when it is defined.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        fetch_misaligned;
   logic        s_mis;
`endif

   logic [31:0] mem_q[$];
   logic        s_req, s_valid;
   logic [31:0] s_addr, s_pc, s_instr;
   int          n_cmp = 0;
   int          n_err = 0;

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .fetch_misaligned (fetch_misaligned)
`endif
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs and memory response, sample outputs,
   // then update the memory model with what transferred at the edge.
   task automatic step(input logic st, input logic rv, input logic [31:0] rpc,
                       input logic gn, input logic re);
      stall          = st;
      redirect_valid = rv;
      redirect_pc    = rpc;
      imem_gnt       = gn;
      imem_rvalid    = re && (mem_q.size() != 0);
      imem_rdata     = imem_rvalid ? instr_of(mem_q[0]) : 32'h0;
      #1;
      s_req   = imem_req;
      s_addr  = imem_addr;
      s_valid = if_valid;
      s_pc    = if_pc;
      s_instr = if_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
      s_mis   = fetch_misaligned;
`endif
      @(posedge clk);
      if (imem_rvalid) void'(mem_q.pop_front());
      if (s_req && gn) mem_q.push_back(s_addr);
      @(negedge clk);
   endtask

   task automatic expect_head(input string tag, input logic [31:0] pc);
      check_eq({tag, "_valid"}, {31'b0, s_valid}, 32'd1);
      check_eq({tag, "_pc"}, s_pc, pc);
      check_eq({tag, "_instr"}, s_instr, instr_of(pc));
   endtask

   task automatic expect_empty(input string tag);
      check_eq({tag, "_valid"}, {31'b0, s_valid}, 32'd0);
      check_eq({tag, "_pc"}, s_pc, 32'h0);
      check_eq({tag, "_instr"}, s_instr, NOP);
   endtask

   task automatic expect_req(input string tag, input logic [31:0] addr);
      check_eq({tag, "_req"}, {31'b0, s_req}, 32'd1);
      check_eq({tag, "_addr"}, s_addr, addr);
   endtask

   task automatic expect_noreq(input string tag);
      check_eq({tag, "_req"}, {31'b0, s_req}, 32'd0);
   endtask

   logic [31:0] gnt_pc_tbl [3] = '{32'h20, 32'h24, 32'h0};

   initial begin
      rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      @(negedge clk);

      // Reset state.
      step(0, 0, 0, 1, 1);
      expect_noreq("rst0");
      step(0, 0, 0, 1, 1);
      expect_noreq("rst1");
      expect_empty("rst");
      rst = 1'b1;

      // Sequential fetch, 1-cycle memory, no stall.
      for (int k = 0; k < 6; k++) begin
         step(0, 0, 0, 1, 1);
         expect_req("seq", 32'(4 * k));
         if (k >= 2) expect_head("seq", 32'(4 * (k - 2)));
         else check_eq("seq_valid_early", {31'b0, s_valid}, 32'd0);
      end

      // Stall for 5 cycles: buffer fills, requests stop, head held.
      for (int k = 0; k < 5; k++) begin
         step(1, 0, 0, 1, 1);
         expect_noreq("stall");
         expect_head("stall", 32'h10);
      end
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 0, 1, 1);
         expect_head("unstall", 32'(16 + 4 * k));
         expect_req("unstall", 32'(24 + 4 * k));
      end

      // Grant withheld for 3 cycles: address held, pipeline drains.
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 0, 1);
         expect_req("nognt", 32'h28);
         if (k < 2) expect_head("nognt", gnt_pc_tbl[k]);
         else expect_empty("nognt");
      end
      step(0, 0, 0, 1, 1);
      expect_req("regnt0", 32'h28);
      expect_empty("regnt0");
      step(0, 0, 0, 1, 1);
      expect_req("regnt1", 32'h2C);
      expect_empty("regnt1");
      step(0, 0, 0, 1, 1);
      expect_head("regnt2", 32'h28);

      // Redirect with two requests outstanding.
      step(0, 0, 0, 1, 0);
      expect_req("out2a", 32'h34);
      expect_head("out2a", 32'h2C);
      step(0, 0, 0, 1, 0);
      expect_noreq("out2b");
      step(0, 1, 32'h100, 1, 0);
      expect_noreq("redir");
      step(0, 0, 0, 1, 1);
      expect_noreq("drop0");
      expect_empty("drop0");
      step(0, 0, 0, 1, 1);
      expect_req("drop1", 32'h100);
      expect_empty("drop1");
      step(0, 0, 0, 1, 1);
      expect_req("drop2", 32'h104);
      expect_empty("drop2");
      step(0, 0, 0, 1, 1);
      expect_head("redir_h0", 32'h100);
      step(0, 0, 0, 1, 1);
      expect_head("redir_h1", 32'h104);

      // Redirect coinciding with rvalid and stall.
      step(1, 1, 32'h200, 1, 1);
      expect_noreq("rsv");
      step(0, 0, 0, 1, 1);
      expect_req("rsv1", 32'h200);
      expect_empty("rsv1");
      step(0, 0, 0, 1, 1);
      expect_empty("rsv2");
      step(0, 0, 0, 1, 1);
      expect_head("rsv3", 32'h200);

      // pc wraps past the top of the address space.
      step(0, 1, 32'hFFFF_FFFC, 1, 1);
      expect_noreq("wrap0");
      step(0, 0, 0, 1, 1);
      expect_req("wrap1", 32'hFFFF_FFFC);
      step(0, 0, 0, 1, 1);
      expect_req("wrap2", 32'h0);
      step(0, 0, 0, 1, 1);
      expect_head("wrap3", 32'hFFFF_FFFC);
      step(0, 0, 0, 1, 1);
      expect_head("wrap4", 32'h0);

      // Reset mid-transfer; memory is reset alongside.
      rst = 1'b0;
      mem_q.delete();
      step(0, 0, 0, 1, 1);
      expect_noreq("mrst");
      rst = 1'b1;
      step(0, 0, 0, 1, 1);
      expect_req("mrst1", 32'h0);
      expect_empty("mrst1");
      step(0, 0, 0, 1, 1);
      expect_req("mrst2", 32'h4);
      step(0, 0, 0, 1, 1);
      expect_head("mrst3", 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
      // Misaligned redirect halts fetch until an aligned redirect.
      step(0, 1, 32'h102, 1, 1);
      expect_noreq("mis0");
      for (int k = 0; k < 2; k++) begin
         step(0, 0, 0, 1, 1);
         expect_noreq("mis_halt");
         expect_empty("mis_halt");
         check_eq("mis_flag", {31'b0, s_mis}, 32'd1);
      end
      step(0, 1, 32'h200, 1, 1);
      expect_noreq("mis_clr0");
      step(0, 0, 0, 1, 1);
      expect_req("mis_clr1", 32'h200);
      check_eq("mis_flag_clr", {31'b0, s_mis}, 32'd0);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);
      expect_head("mis_clr3", 32'h200);
`else
      // Without the check, low address bits pass straight through.
      step(0, 1, 32'h102, 1, 1);
      expect_noreq("una0");
      step(0, 0, 0, 1, 1);
      expect_req("una1", 32'h102);
      step(0, 0, 0, 1, 1);
      expect_req("una2", 32'h106);
      step(0, 0, 0, 1, 1);
      expect_head("una3", 32'h102);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
